dht11_interface: RTL
====================

DHT11_INTERFACE -- requirements
Module: dht11_interface

Interface
REQ-001 Parameter TICKS_PER_US, default 50, i_Clock cycles per microsecond.
REQ-002 Parameter START_LOW_US, default 18000, host start-pulse low time in microseconds.
REQ-003 Parameter TIMEOUT_US, default 255, maximum wait per sensor phase before error.
REQ-004 i_Clock  in  1  system clock; all state changes on its rising edge.
REQ-005 i_Rst_n  in  1  reset, asynchronous and active-low.
REQ-006 i_Enable  in  1  one-cycle strobe from the selector's interface bit 0; starts a transaction.
REQ-007 i_Request  in  8  request code, sampled on the i_Enable cycle.
REQ-008 io_Dht_Data  inout  1  sensor single-wire line; driven only to 0, otherwise high-Z (external pull-up).
REQ-009 o_Response  out  8  response code toward the TX packer.
REQ-010 o_Value  out  8  data byte accompanying o_Response.
REQ-011 o_Done  out  1  one-cycle pulse; o_Response and o_Value are valid on it and held afterwards.
REQ-012 o_Busy  out  1  high from the cycle after an accepted i_Enable until the o_Done cycle.

Function
REQ-013 Request codes: 0x03 status, 0x04 temperature integer byte, 0x05 humidity integer byte; any other code is invalid.
REQ-014 Invalid code: no bus activity; o_Done pulses 1 cycle after i_Enable with o_Response=0xCF and o_Value=0x00.
REQ-015 States: IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK, DONE.
REQ-016 IDLE->START_LOW on i_Enable with a valid code; the line is driven 0 for START_LOW_US*TICKS_PER_US cycles.
REQ-017 RELEASE: line high-Z; wait for the line to go low, at most 40 us; the falling edge enters RESP_LOW.
REQ-018 RESP_LOW waits for the line to go high; RESP_HIGH waits for the line to go low, then enters BIT_LOW.
REQ-019 BIT_LOW waits for high; BIT_HIGH counts high time; on the falling edge the bit is 1 if high time > 40 us, else 0.
REQ-020 Bits shift MSB-first into a 40-bit register: hum_int, hum_dec, temp_int, temp_dec, checksum; after bit 40 go to CHECK.
REQ-021 Every wait state has a microsecond counter, cleared on state entry; reaching TIMEOUT_US goes to DONE with error.
REQ-022 Error response: o_Response=0x1F, o_Value=0x00.
REQ-023 Success: 0x03 -> 0x07/0x00; 0x04 -> 0x09/temp_int; 0x05 -> 0x08/hum_int.
REQ-024 The line is sampled through a 2-flop synchroniser; edges are detected on the synchronised value.
REQ-025 i_Enable while o_Busy is ignored; no queueing.
REQ-026 DONE asserts o_Done for one cycle and then returns to IDLE; back-to-back requests need no gap.
REQ-027 Bit counter is 6 bits and saturates at 40; the microsecond counter is 16 bits and must not wrap.

Reset
REQ-028 Asynchronous reset forces IDLE, releases the line to high-Z and clears o_Response, o_Value, o_Done, o_Busy and all counters to 0.
REQ-029 Reset during a transaction aborts it with no o_Done pulse.

Configuration
REQ-030 Macro DHT_CHECKSUM_EN defined: in CHECK, a mismatch between (sum of the first four bytes mod 256) and checksum gives the error response.
REQ-031 Macro DHT_CHECKSUM_EN undefined: the checksum byte is shifted in but ignored, and CHECK always reports success.

Structure
REQ-032 Shared package dht_pkg holds the state enum, request codes, response codes and timing constants (40 us threshold, 40 us release timeout).
REQ-033 One sub-module, dht_us_tick, generates a one-cycle pulse every TICKS_PER_US cycles, restarted on each state change.

Verification
REQ-034 The bench uses TICKS_PER_US=1 and START_LOW_US=100 in all scenarios.
REQ-035 Invalid request: i_Request=0x42 -> o_Done pulses on the next cycle with 0xCF/0x00 and the line never goes low.
REQ-036 Temperature: sensor model sends 0x37,0x00,0x19,0x00,0x50 -> response 0x09/0x19 (hum 55, temp 25).
REQ-037 Humidity: same frame -> response 0x08/0x37; status request -> 0x07/0x00.
REQ-038 Silent sensor: line stays high after release -> 0x1F/0x00 after 40 us.
REQ-039 Checksum error: frame with checksum 0x51 -> 0x1F/0x00 with DHT_CHECKSUM_EN defined, and 0x09/0x19 without it.
REQ-040 Reset mid-frame: pulse i_Rst_n low at bit 20 -> line high-Z, o_Busy=0, no o_Done; the next request completes normally.

Source files
------------

// File: rtl/dht_pkg.sv
// Shared types and constants for the DHT11 single-wire sensor interface:
// FSM states, request/response codes and protocol timing thresholds.
package dht_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START_LOW,
        ST_RELEASE,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_CHECK,
        ST_DONE
    } dht_state_e;

    localparam logic [7:0] REQ_STATUS  = 8'h03;
    localparam logic [7:0] REQ_TEMP    = 8'h04;
    localparam logic [7:0] REQ_HUM     = 8'h05;

    localparam logic [7:0] RSP_STATUS  = 8'h07;
    localparam logic [7:0] RSP_HUM     = 8'h08;
    localparam logic [7:0] RSP_TEMP    = 8'h09;
    localparam logic [7:0] RSP_ERROR   = 8'h1F;
    localparam logic [7:0] RSP_INVALID = 8'hCF;

    // A data bit whose high phase lasts longer than this is a '1'.
    localparam int unsigned BIT_ONE_US         = 40;
    localparam int unsigned RELEASE_TIMEOUT_US = 40;
    localparam int unsigned FRAME_BITS         = 40;

    function automatic logic req_valid(input logic [7:0] req);
        return (req == REQ_STATUS) || (req == REQ_TEMP) || (req == REQ_HUM);
    endfunction

    // Sum of the four payload bytes, wrapping modulo 256 like the sensor does.
    function automatic logic [7:0] frame_sum(input logic [39:0] frame);
        return frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    endfunction

endpackage

// File: rtl/dht11_interface_if.sv
// Request/response handshake between the command selector and the DHT11 block.
interface dht11_interface_if;

    logic       i_Enable;
    logic [7:0] i_Request;
    logic [7:0] o_Response;
    logic [7:0] o_Value;
    logic       o_Done;
    logic       o_Busy;

    modport master (
        output i_Enable, i_Request,
        input  o_Response, o_Value, o_Done, o_Busy
    );

    modport slave (
        input  i_Enable, i_Request,
        output o_Response, o_Value, o_Done, o_Busy
    );

endinterface

// File: rtl/dht_us_tick.sv
// Microsecond strobe: one-cycle pulse every TICKS_PER_US clocks, with the
// count restarted so the first pulse lands exactly one microsecond after restart.
module dht_us_tick #(
    parameter int unsigned TICKS_PER_US = 50
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned CW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_US - 1);

    logic [CW-1:0] cnt_q, cnt_d, cnt_eff;
    logic          tick;

    // The restart cycle itself counts as cycle 0 of the new microsecond.
    always_comb begin
        cnt_eff = restart_i ? '0 : cnt_q;
        tick    = (cnt_eff == LAST);
        cnt_d   = tick ? '0 : cnt_eff + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign tick_o = tick;

endmodule

// File: rtl/dht11_interface.sv
// DHT11 host controller: issues the start pulse, decodes the 40-bit frame and
// answers status/temperature/humidity requests. Define DHT_CHECKSUM_EN to reject bad checksums.
module dht11_interface
    import dht_pkg::*;
#(
    parameter int unsigned TICKS_PER_US = 50,
    parameter int unsigned START_LOW_US = 18000,
    parameter int unsigned TIMEOUT_US   = 255
) (
    input  logic               i_Clock,
    input  logic               i_Rst_n,
    dht11_interface_if.slave   bus,
    inout  wire                io_Dht_Data
);

    localparam logic [15:0] START_LAST = 16'(START_LOW_US - 1);
    localparam logic [15:0] REL_LAST   = 16'(RELEASE_TIMEOUT_US - 1);
    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_US - 1);
    localparam logic [15:0] BIT_ONE    = 16'(BIT_ONE_US);
    localparam logic [5:0]  LAST_BIT   = 6'(FRAME_BITS - 1);
    localparam logic [5:0]  BIT_SAT    = 6'(FRAME_BITS);

    dht_state_e  state_q;
    logic [7:0]  req_q;
    logic [15:0] us_cnt_q;
    logic [5:0]  bit_cnt_q;
    logic [39:0] data_q;
    logic        drive_low_q;
    logic        restart_q;
    logic [7:0]  rsp_q, val_q;
    logic        done_q, busy_q;
    logic [1:0]  sync_q;
    logic        prev_q;

    logic line_s, rise, fall, tick, csum_ok;

    assign io_Dht_Data = drive_low_q ? 1'b0 : 1'bz;

    // Two-flop synchroniser plus one history flop for edge detection; idles high.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], io_Dht_Data};
            prev_q <= sync_q[1];
        end
    end

    assign line_s = sync_q[1];
    assign rise   = line_s & ~prev_q;
    assign fall   = ~line_s & prev_q;

    dht_us_tick #(
        .TICKS_PER_US (TICKS_PER_US)
    ) u_tick (
        .clk_i     (i_Clock),
        .rst_ni    (i_Rst_n),
        .restart_i (restart_q),
        .tick_o    (tick)
    );

`ifdef DHT_CHECKSUM_EN
    assign csum_ok = (frame_sum(data_q) == data_q[7:0]);
`else
    assign csum_ok = 1'b1;
`endif

    function automatic logic [15:0] success_rsp(input logic [7:0] req, input logic [39:0] frame);
        case (req)
            REQ_TEMP: return {RSP_TEMP, frame[23:16]};
            REQ_HUM:  return {RSP_HUM, frame[39:32]};
            default:  return {RSP_STATUS, 8'h00};
        endcase
    endfunction

    // Every state entry restarts the microsecond strobe and clears the wait counter.
    task automatic enter(input dht_state_e s);
        state_q   <= s;
        restart_q <= 1'b1;
        us_cnt_q  <= '0;
    endtask

    task automatic finish(input logic [15:0] rsp);
        enter(ST_DONE);
        rsp_q  <= rsp[15:8];
        val_q  <= rsp[7:0];
        done_q <= 1'b1;
    endtask

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            us_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            data_q      <= '0;
            drive_low_q <= 1'b0;
            restart_q   <= 1'b0;
            rsp_q       <= '0;
            val_q       <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            restart_q <= 1'b0;
            if (tick && (us_cnt_q != 16'hFFFF)) us_cnt_q <= us_cnt_q + 16'd1;

            case (state_q)
                ST_IDLE: begin
                    if (bus.i_Enable) begin
                        busy_q <= 1'b1;
                        req_q  <= bus.i_Request;
                        if (req_valid(bus.i_Request)) begin
                            drive_low_q <= 1'b1;
                            bit_cnt_q   <= '0;
                            enter(ST_START_LOW);
                        end else begin
                            finish({RSP_INVALID, 8'h00});
                        end
                    end
                end
                ST_START_LOW: begin
                    if (tick && (us_cnt_q == START_LAST)) begin
                        drive_low_q <= 1'b0;
                        enter(ST_RELEASE);
                    end
                end
                ST_RELEASE: begin
                    if (fall)                                enter(ST_RESP_LOW);
                    else if (tick && (us_cnt_q == REL_LAST)) finish({RSP_ERROR, 8'h00});
                end
                ST_RESP_LOW: begin
                    if (rise)                               enter(ST_RESP_HIGH);
                    else if (tick && (us_cnt_q == TO_LAST)) finish({RSP_ERROR, 8'h00});
                end
                ST_RESP_HIGH: begin
                    if (fall)                               enter(ST_BIT_LOW);
                    else if (tick && (us_cnt_q == TO_LAST)) finish({RSP_ERROR, 8'h00});
                end
                ST_BIT_LOW: begin
                    if (rise)                               enter(ST_BIT_HIGH);
                    else if (tick && (us_cnt_q == TO_LAST)) finish({RSP_ERROR, 8'h00});
                end
                ST_BIT_HIGH: begin
                    // The high-phase length, measured in microseconds, encodes the bit.
                    if (fall) begin
                        data_q <= {data_q[38:0], (us_cnt_q > BIT_ONE)};
                        if (bit_cnt_q != BIT_SAT) bit_cnt_q <= bit_cnt_q + 6'd1;
                        if (bit_cnt_q == LAST_BIT) enter(ST_CHECK);
                        else                       enter(ST_BIT_LOW);
                    end else if (tick && (us_cnt_q == TO_LAST)) begin
                        finish({RSP_ERROR, 8'h00});
                    end
                end
                ST_CHECK: begin
                    if (csum_ok) finish(success_rsp(req_q, data_q));
                    else         finish({RSP_ERROR, 8'h00});
                end
                ST_DONE: begin
                    busy_q <= 1'b0;
                    enter(ST_IDLE);
                end
                default: begin
                    drive_low_q <= 1'b0;
                    busy_q      <= 1'b0;
                    enter(ST_IDLE);
                end
            endcase
        end
    end

    assign bus.o_Response = rsp_q;
    assign bus.o_Value    = val_q;
    assign bus.o_Done     = done_q;
    assign bus.o_Busy     = busy_q;

endmodule
